// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// Connects the MIPS execute/memory stage to a word-addressed data memory.
// The unit takes byte, halfword and word loads and stores on a byte address
// and turns each one into one or two word accesses.
//   - Loads are sign-extended, or zero-extended when req_unsigned is set.
//   - Sub-word stores are a read-modify-write: one read cycle, then one write
//     cycle.
//   - Illegal requests (size 11, out of range, or misaligned when checked)
//     return an error response and never reach memory.
//
// Configuration macro:
//   DMEM_ALIGN_CHECK_EN
//     defined   : a misaligned halfword or word request gets an error
//                 response.
//     undefined : addr[0] is ignored for halfwords and addr[1:0] is ignored
//                 for words. Only the range and size checks remain.
//
// Ports:
//   CLK           rising-edge clock
//   RST           asynchronous active-low reset
//   req_valid     request present
//   req_ready     high in IDLE; accept = req_valid & req_ready at a rising edge
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  zero-extend a sub-word load when set
//   req_addr      byte address
//   req_wdata     store data, right-justified
//   rsp_valid     one-cycle response pulse
//   rsp_rdata     extended load data; 0 for stores and errors; held between
//                 responses
//   rsp_error     response qualifier: request was rejected
//   mem_A         memory word index (req_addr >> 2)
//   mem_WD        memory write data
//   mem_WE        memory write enable, decoded from the current state
//   mem_RD        combinational memory read data at mem_A
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 100
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;
    localparam logic [1:0] SizeBad  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] MemDepthW = ADDR_WIDTH'(MEM_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWrite,
        StResp,
        StErr
    } state_e;

    state_e                  state_q;
    logic                    write_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   merge_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    rsp_valid_q;
    logic                    rsp_error_q;

    // ------------------------------------------------------------------------
    // Legality check on the incoming request
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_misaligned;
    logic                  req_illegal;

    assign req_idx = {2'b00, req_addr[ADDR_WIDTH-1:2]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_misaligned = ((req_size == SizeHalf) && req_addr[0]) ||
                            ((req_size == SizeWord) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    assign req_illegal = (req_size == SizeBad) || (req_idx >= MemDepthW) || req_misaligned;

    // ------------------------------------------------------------------------
    // Load lane extraction and extension
    // ------------------------------------------------------------------------
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_ext;

    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: ld_byte = mem_RD[7:0];
            2'd1: ld_byte = mem_RD[15:8];
            2'd2: ld_byte = mem_RD[23:16];
            2'd3: ld_byte = mem_RD[31:24];
            default: ld_byte = 8'h00;
        endcase
        // addr[0] does not take part in halfword lane selection.
        ld_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

        ld_ext = mem_RD;
        if (size_q == SizeByte) begin
            ld_ext = unsigned_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (size_q == SizeHalf) begin
            ld_ext = unsigned_q ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    // ------------------------------------------------------------------------
    // Sub-word store merge: the old word with the addressed lanes replaced
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = merge_q;
        if (size_q == SizeByte) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = merge_q;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merge_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            // The response flags are single-cycle pulses. They are set only
            // on the transition into RESP or ERR.
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        if (req_illegal) begin
                            state_q     <= StErr;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rdata_q     <= '0;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end

                StAccess: begin
                    if (!write_q) begin
                        rdata_q     <= ld_ext;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (size_q == SizeWord) begin
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        merge_q <= mem_RD;
                        state_q <= StWrite;
                    end
                end

                StWrite: begin
                    rdata_q     <= '0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end

                StResp:  state_q <= StIdle;
                StErr:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The memory controls are decoded from state_q, so an asynchronous reset
    // drops mem_WE at once and no partial write can complete.
    logic in_mem_phase;

    assign in_mem_phase = (state_q == StAccess) || (state_q == StWrite);

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_rdata = rdata_q;

    assign mem_A  = in_mem_phase ? {2'b00, addr_q[ADDR_WIDTH-1:2]} : '0;
    assign mem_WE = (state_q == StWrite) ||
                    ((state_q == StAccess) && write_q && (size_q == SizeWord));

    always_comb begin
        mem_WD = '0;
        if (state_q == StWrite) begin
            mem_WD = merged;
        end else if ((state_q == StAccess) && write_q && (size_q == SizeWord)) begin
            mem_WD = wdata_q;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit. It contains:
//   - a 100-word data memory attached to the DUT;
//   - a reference model that computes each response and each memory update
//     with plain arithmetic on a shadow memory array;
//   - a table of directed vectors;
//   - a hand-written sequence that resets the DUT in the middle of a
//     read-modify-write;
//   - a randomized sweep.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int Depth = 100;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_A;
    logic [31:0] mem_WD;
    logic        mem_WE;
    logic [31:0] mem_RD;

    load_store_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_DEPTH (Depth)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .mem_A       (mem_A),
        .mem_WD      (mem_WD),
        .mem_WE      (mem_WE),
        .mem_RD      (mem_RD)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------------
    // Data memory. It is filled with a known pattern on the first clock edge.
    // ------------------------------------------------------------------------
    logic [31:0] tb_mem [0:Depth-1];
    logic        mem_init_done = 1'b0;
    int          we_count = 0;

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h01030507) ^ 32'hC0FFEE00;
    endfunction

    always @(posedge CLK) begin
        if (!mem_init_done) begin
            for (int i = 0; i < Depth; i++) tb_mem[i] <= init_val(i);
            mem_init_done <= 1'b1;
        end else if (mem_WE) begin
            we_count <= we_count + 1;
            if (mem_A < 32'(Depth)) tb_mem[mem_A[6:0]] <= mem_WD;
        end
    end

    assign mem_RD = (mem_A < 32'(Depth)) ? tb_mem[mem_A[6:0]] : 32'h0;

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [0:Depth-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: computes the expected response and memory effect of a
    // request from the shadow memory.
    // ------------------------------------------------------------------------
    function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic e_err, output logic [31:0] e_rd,
                                  output logic e_wr, output logic [31:0] e_word,
                                  output int idx);
        logic        mis;
        int          bpos;
        int          hpos;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        idx  = int'(a >> 2);
        mis  = ((sz == 2'd1) && (a % 2 != 0)) || ((sz == 2'd2) && (a % 4 != 0));
`ifdef DMEM_ALIGN_CHECK_EN
        e_err = (sz == 2'd3) || (idx >= Depth) || mis;
`else
        e_err = (sz == 2'd3) || (idx >= Depth);
`endif
        e_rd   = 32'h0;
        e_wr   = 1'b0;
        e_word = 32'h0;
        if (e_err) return;
        word = ref_mem[idx];
        bpos = int'(a % 4);
        hpos = int'((a / 2) % 2) * 2;
        if (!w) begin
            if (sz == 2'd0) begin
                v = (word >> (8 * bpos)) & 32'hFF;
                if (!uns && v >= 32'd128) v = v + 32'hFFFFFF00;
            end else if (sz == 2'd1) begin
                v = (word >> (8 * hpos)) & 32'hFFFF;
                if (!uns && v >= 32'd32768) v = v + 32'hFFFF0000;
            end else begin
                v = word;
            end
            e_rd = v;
        end else begin
            e_wr = 1'b1;
            if (sz == 2'd0) begin
                mask   = 32'hFF << (8 * bpos);
                e_word = (word & ~mask) | ((wd & 32'hFF) << (8 * bpos));
            end else if (sz == 2'd1) begin
                mask   = 32'hFFFF << (8 * hpos);
                e_word = (word & ~mask) | ((wd & 32'hFFFF) << (8 * hpos));
            end else begin
                e_word = wd;
            end
        end
    endfunction

    // ------------------------------------------------------------------------
    // Runs one request end to end and checks it against the model.
    // While the DUT is busy, req_valid stays high with random fields to show
    // that they are ignored.
    // ------------------------------------------------------------------------
    task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic g_err, output logic [31:0] g_rd);
        logic        e_err;
        logic        e_wr;
        logic [31:0] e_rd;
        logic [31:0] e_word;
        int          idx;
        int          lat;
        int          exp_lat;
        int          we0;
        model(w, sz, uns, a, wd, e_err, e_rd, e_wr, e_word, idx);
        we0 = we_count;
        @(negedge CLK);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge CLK);
        #1;
        req_write    = 1'($urandom_range(0, 1));
        req_size     = 2'($urandom_range(0, 3));
        req_unsigned = 1'($urandom_range(0, 1));
        req_addr     = 32'($urandom_range(0, 399));
        req_wdata    = $urandom;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        req_valid = 1'b0;
        g_err = rsp_error;
        g_rd  = rsp_rdata;
        exp_lat = e_err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_error", 32'(g_err), 32'(e_err));
        check("rsp_rdata", g_rd, e_rd);
        check("write_count", 32'(we_count - we0), 32'(e_wr));
        if (e_wr) ref_mem[idx] = e_word;
        if (idx < Depth) check("mem_word", tb_mem[idx], ref_mem[idx]);
        @(negedge CLK);
        check("rsp_pulse", 32'(rsp_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
        check("rdata_hold", rsp_rdata, g_rd);
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [$];

    task automatic add_vec(input logic w, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic err, input logic [31:0] rd);
        vec_t v;
        v.w = w; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.err = err; v.rd = rd;
        vecs.push_back(v);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin : main
        logic        g_err;
        logic [31:0] g_rd;
        int          we0;
        int          mism;

        for (int i = 0; i < Depth; i++) ref_mem[i] = init_val(i);
        RST          = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_mem_we", 32'(mem_WE), 32'd0);
        check("reset_mem_a", mem_A, 32'h0);
        RST = 1'b1;

        //      w     sz     uns   addr       wdata         err   rdata
        add_vec(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000);
        add_vec(1'b0, 2'd2, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'hDEADBEEF);
        add_vec(1'b1, 2'd0, 1'b0, 32'h011, 32'hABCDEF55, 1'b0, 32'h00000000);
        add_vec(1'b0, 2'd2, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'hDEAD55EF);
        add_vec(1'b0, 2'd0, 1'b0, 32'h013, 32'h00000000, 1'b0, 32'hFFFFFFDE);
        add_vec(1'b0, 2'd0, 1'b1, 32'h013, 32'h00000000, 1'b0, 32'h000000DE);
        add_vec(1'b0, 2'd1, 1'b0, 32'h012, 32'h00000000, 1'b0, 32'hFFFFDEAD);
        add_vec(1'b1, 2'd2, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h00000000);
        add_vec(1'b1, 2'd1, 1'b0, 32'h012, 32'h99991234, 1'b0, 32'h00000000);
        add_vec(1'b0, 2'd2, 1'b0, 32'h010, 32'h00000000, 1'b0, 32'h12340000);
        add_vec(1'b0, 2'd1, 1'b1, 32'h012, 32'h00000000, 1'b0, 32'h00001234);
        add_vec(1'b0, 2'd2, 1'b0, 32'h190, 32'h00000000, 1'b1, 32'h00000000);
        add_vec(1'b0, 2'd3, 1'b0, 32'h010, 32'h00000000, 1'b1, 32'h00000000);
        add_vec(1'b1, 2'd0, 1'b0, 32'h190, 32'h000000AA, 1'b1, 32'h00000000);
        add_vec(1'b1, 2'd2, 1'b0, 32'h010, 32'h12348765, 1'b0, 32'h00000000);
`ifdef DMEM_ALIGN_CHECK_EN
        add_vec(1'b0, 2'd1, 1'b0, 32'h011, 32'h00000000, 1'b1, 32'h00000000);
        add_vec(1'b0, 2'd2, 1'b0, 32'h013, 32'h00000000, 1'b1, 32'h00000000);
        add_vec(1'b0, 2'd1, 1'b1, 32'h013, 32'h00000000, 1'b1, 32'h00000000);
`else
        add_vec(1'b0, 2'd1, 1'b0, 32'h011, 32'h00000000, 1'b0, 32'hFFFF8765);
        add_vec(1'b0, 2'd2, 1'b0, 32'h013, 32'h00000000, 1'b0, 32'h12348765);
        add_vec(1'b0, 2'd1, 1'b1, 32'h013, 32'h00000000, 1'b0, 32'h00001234);
`endif
        add_vec(1'b1, 2'd0, 1'b0, 32'h18F, 32'h000000A7, 1'b0, 32'h00000000);
        add_vec(1'b0, 2'd0, 1'b1, 32'h18F, 32'h00000000, 1'b0, 32'h000000A7);
        add_vec(1'b0, 2'd0, 1'b0, 32'h18F, 32'h00000000, 1'b0, 32'hFFFFFFA7);
        add_vec(1'b1, 2'd1, 1'b0, 32'h18E, 32'h0000BEEF, 1'b0, 32'h00000000);
        add_vec(1'b0, 2'd1, 1'b1, 32'h18E, 32'h00000000, 1'b0, 32'h0000BEEF);
        add_vec(1'b0, 2'd1, 1'b0, 32'h18E, 32'h00000000, 1'b0, 32'hFFFFBEEF);

        foreach (vecs[i]) begin
            run_req(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, g_err, g_rd);
            check($sformatf("vec%0d_error", i), 32'(g_err), 32'(vecs[i].err));
            check($sformatf("vec%0d_rdata", i), g_rd, vecs[i].rd);
        end

        // Reset asserted during the write cycle of a byte store
        run_req(1'b1, 2'd2, 1'b0, 32'h020, 32'hA5A5A5A5, g_err, g_rd);
        we0 = we_count;
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr  = 32'h021; req_wdata = 32'h0000003C;
        @(posedge CLK);                 // accepted: access cycle
        #1 req_valid = 1'b0;
        @(posedge CLK);                 // write cycle
        #2;
        check("rmw_we_in_write", 32'(mem_WE), 32'd1);
        check("rmw_addr_in_write", mem_A, 32'd8);
        RST = 1'b0;
        #1;
        check("rst_we_drop", 32'(mem_WE), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_a", mem_A, 32'h0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h020;
        req_wdata = 32'h0BADF00D;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("rst_no_write", 32'(we_count - we0), 32'd0);
        check("rst_word_intact", tb_mem[8], ref_mem[8]);
        run_req(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, g_err, g_rd);
        check("post_rst_load", g_rd, 32'hA5A5A5A5);
        run_req(1'b1, 2'd0, 1'b0, 32'h021, 32'h3C, g_err, g_rd);
        check("post_rst_sb", tb_mem[8], 32'hA5A53CA5);

        // Randomized sweep
        for (int n = 0; n < 250; n++) begin
            logic        w;
            logic [1:0]  sz;
            logic        uns;
            logic [31:0] a;
            int          r;
            w   = 1'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 15));
            sz  = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            uns = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(400, 1023))
                                               : 32'($urandom_range(0, 399));
            run_req(w, sz, uns, a, $urandom, g_err, g_rd);
        end

        mism = 0;
        for (int i = 0; i < Depth; i++) if (tb_mem[i] !== ref_mem[i]) mism++;
        check("mem_sweep_mismatches", 32'(mism), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
